// File: rtl/flow_out_collector.sv
// -----------------------------------------------------------------------------
// flow_out_collector
//
// Receiving end of a tagged multi-flow write stream. Each incoming word
// carries a flow id in its upper TAG_W bits. The word is steered into that
// flow's show-ahead FIFO, and it is counted against the frame length that was
// configured for the flow. Each flow runs a small IDLE/ACTIVE/DONE state
// machine. The flow reports done once its frame has been fully received.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   din        : {tag, data} input word
//   write      : din valid this cycle
//   full       : per-flow back-pressure (registered, occupancy == DEPTH)
//   cfg_din    : {tag, expected_count} frame setup word
//   cfg_write  : cfg_din valid this cycle
//   rd         : per-flow pop strobe (ignored while that FIFO is empty)
//   dout       : per-flow head-of-FIFO data, flow i at [i*DATA_W +: DATA_W]
//   empty      : per-flow FIFO empty
//   done       : per-flow frame complete (level, while in DONE)
//   err        : per-flow sticky error (overflow or unexpected data)
// -----------------------------------------------------------------------------
module flow_out_collector #(
  parameter int FLUX   = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 13,
  parameter int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_W+DATA_W-1:0]  din,
  input  logic                     write,
  output logic [FLUX-1:0]          full,
  input  logic [TAG_W+CNT_W-1:0]   cfg_din,
  input  logic                     cfg_write,
  input  logic [FLUX-1:0]          rd,
  output logic [FLUX*DATA_W-1:0]   dout,
  output logic [FLUX-1:0]          empty,
  output logic [FLUX-1:0]          done,
  output logic [FLUX-1:0]          err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } flow_state_e;

  // Input field split
  logic [TAG_W-1:0]  din_tag;
  logic [DATA_W-1:0] din_data;
  logic [TAG_W-1:0]  cfg_tag;
  logic [CNT_W-1:0]  cfg_cnt;

  assign din_tag  = din[TAG_W+DATA_W-1 -: TAG_W];
  assign din_data = din[DATA_W-1:0];
  assign cfg_tag  = cfg_din[TAG_W+CNT_W-1 -: TAG_W];
  assign cfg_cnt  = cfg_din[CNT_W-1:0];

  // Per-flow state
  flow_state_e       state    [FLUX];
  logic [CNT_W-1:0]  exp_cnt  [FLUX];
  logic [CNT_W-1:0]  rcv_cnt  [FLUX];
  logic [PTR_W-1:0]  wr_ptr   [FLUX];
  logic [PTR_W-1:0]  rd_ptr   [FLUX];
  logic [OCC_W-1:0]  occ      [FLUX];
  logic [DATA_W-1:0] mem      [FLUX][DEPTH];

  // Next-state values
  flow_state_e       state_nx [FLUX];
  logic [CNT_W-1:0]  exp_nx   [FLUX];
  logic [CNT_W-1:0]  rcv_nx   [FLUX];
  logic [OCC_W-1:0]  occ_nx   [FLUX];
  logic [FLUX-1:0]   cfg_hit;
  logic [FLUX-1:0]   wr_hit;
  logic [FLUX-1:0]   push;
  logic [FLUX-1:0]   pop;
  logic [FLUX-1:0]   err_set;

  // Tag decode. A tag >= FLUX matches no flow, so that word is silently
  // dropped without any state change.
  always_comb begin
    cfg_hit = '0;
    wr_hit  = '0;
    for (int i = 0; i < FLUX; i++) begin
      cfg_hit[i] = cfg_write && (cfg_tag == TAG_W'(i));
      wr_hit[i]  = write     && (din_tag == TAG_W'(i));
    end
  end

  // Per-flow next state. A same-cycle config is applied first, and a
  // same-cycle write is then judged against the freshly configured flow.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      state_nx[i] = state[i];
      exp_nx[i]   = exp_cnt[i];
      rcv_nx[i]   = rcv_cnt[i];
      push[i]     = 1'b0;
      err_set[i]  = 1'b0;

      if (cfg_hit[i]) begin
        exp_nx[i]   = cfg_cnt;
        rcv_nx[i]   = '0;
        state_nx[i] = (cfg_cnt == '0) ? DONE : ACTIVE;
      end

      if (wr_hit[i]) begin
        // full is the registered flag, so a pop in this same cycle does not
        // free a slot for this write.
        if (state_nx[i] == ACTIVE && !full[i]) begin
          push[i]   = 1'b1;
          rcv_nx[i] = rcv_nx[i] + CNT_W'(1);
          if (rcv_nx[i] == exp_nx[i]) begin
            state_nx[i] = DONE;
          end
        end else begin
          err_set[i] = 1'b1;
        end
      end

      pop[i] = rd[i] && (occ[i] != '0);

      unique case ({push[i], pop[i]})
        2'b10:   occ_nx[i] = occ[i] + OCC_W'(1);
        2'b01:   occ_nx[i] = occ[i] - OCC_W'(1);
        default: occ_nx[i] = occ[i];
      endcase
    end
  end

  // Control registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state[i]   <= IDLE;
        exp_cnt[i] <= '0;
        rcv_cnt[i] <= '0;
        wr_ptr[i]  <= '0;
        rd_ptr[i]  <= '0;
        occ[i]     <= '0;
      end
      full <= '0;
      done <= '0;
      err  <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        state[i]   <= state_nx[i];
        exp_cnt[i] <= exp_nx[i];
        rcv_cnt[i] <= rcv_nx[i];
        occ[i]     <= occ_nx[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        full[i] <= (occ_nx[i] == OCC_W'(DEPTH));
        done[i] <= (state_nx[i] == DONE);
        err[i]  <= err[i] | err_set[i];
      end
    end
  end

  // FIFO storage
  // NOTE: the storage array has no reset. The occupancy counter makes any
  // stale word unreachable, so clearing it would add only reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din_data;
    end
  end

  // Show-ahead outputs. The head word is visible while the FIFO is non-empty,
  // and the slice reads zero otherwise, which also gives dout = 0 out of reset.
  always_comb begin
    dout  = '0;
    empty = '0;
    for (int i = 0; i < FLUX; i++) begin
      empty[i] = (occ[i] == '0);
      if (occ[i] != '0) begin
        dout[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
      end
    end
  end

endmodule

// File: tb/tb_flow_out_collector.sv
// -----------------------------------------------------------------------------
// tb_flow_out_collector
//
// Directed bench for flow_out_collector. Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_flow_out_collector;

  localparam int FLUX   = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 13;
  localparam int TAG_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [TAG_W+DATA_W-1:0] din = '0;
  logic                    write = 1'b0;
  logic [FLUX-1:0]         full;
  logic [TAG_W+CNT_W-1:0]  cfg_din = '0;
  logic                    cfg_write = 1'b0;
  logic [FLUX-1:0]         rd = '0;
  logic [FLUX*DATA_W-1:0]  dout;
  logic [FLUX-1:0]         empty;
  logic [FLUX-1:0]         done;
  logic [FLUX-1:0]         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flow_out_collector #(
    .FLUX(FLUX), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
    .cfg_din(cfg_din), .cfg_write(cfg_write), .rd(rd), .dout(dout),
    .empty(empty), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice(input int k);
    return dout[k*DATA_W +: DATA_W];
  endfunction

  task automatic do_cfg(input int t, input int n);
    cfg_din   = {TAG_W'(t), CNT_W'(n)};
    cfg_write = 1'b1;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic do_wr(input int t, input int d);
    din   = {TAG_W'(t), DATA_W'(d)};
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_full",  full,  4'h0);
    check("rst_empty", empty, 4'hF);
    check("rst_done",  done,  4'h0);
    check("rst_err",   err,   4'h0);
    check("rst_dout",  dout,  32'h0);

    // Single flow: 256 words, popped the cycle after each push
    do_cfg(0, 256);
    rd = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      din   = {TAG_W'(0), DATA_W'(i)};
      write = 1'b1;
      tick();
      check($sformatf("sf_dout_%0d", i), slice(0), i & 8'hFF);
      check($sformatf("sf_done_%0d", i), done[0], (i == 255) ? 1 : 0);
    end
    write = 1'b0;
    tick();
    rd = '0;
    check("sf_empty", empty[0], 1);
    check("sf_err",   err,      4'h0);
    check("sf_done",  done[0],  1);

    // Back-pressure on flow 2
    do_cfg(2, 20);
    for (int j = 0; j < 20; j++) begin
      do_wr(2, j);
      if (j == 14) check("bp_not_full_15", full[2], 0);
      if (j == 15) check("bp_full_16",     full[2], 1);
      if (j == 15) check("bp_noerr_16",    err[2],  0);
      if (j == 16) check("bp_err_17",      err[2],  1);
    end
    check("bp_err",  err,     4'b0100);
    check("bp_done", done[2], 0);
    rd = 4'b0100;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("bp_drain_%0d", j), slice(2), j);
      tick();
    end
    rd = '0;
    check("bp_empty", empty[2], 1);
    check("bp_full0", full[2],  0);
    // rcv stayed at 16, so four more words finish the 20-word frame
    for (int j = 0; j < 4; j++) begin
      do_wr(2, 8'h50 + j);
      check($sformatf("bp_tail_done_%0d", j), done[2], (j == 3) ? 1 : 0);
    end
    rd = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_tail_%0d", j), slice(2), 8'h50 + j);
      tick();
    end
    rd = '0;

    // Unexpected data on unconfigured flow 1
    do_wr(1, 8'h77);
    check("ux_err",   err,      4'b0110);
    check("ux_empty", empty[1], 1);
    do_cfg(1, 0);
    check("ux_done",  done[1],  1);

    // Same-cycle config and write on flow 3
    cfg_din   = {TAG_W'(3), CNT_W'(4)};
    cfg_write = 1'b1;
    din       = {TAG_W'(3), DATA_W'(8'hA0)};
    write     = 1'b1;
    tick();
    cfg_write = 1'b0;
    write     = 1'b0;
    check("sim_empty3", empty[3], 0);
    check("sim_dout3",  slice(3), 8'hA0);
    check("sim_done3a", done[3],  0);
    for (int j = 1; j < 4; j++) begin
      do_wr(3, 8'hA0 + j);
      check($sformatf("sim_done3_%0d", j), done[3], (j == 3) ? 1 : 0);
    end
    check("sim_err3", err[3], 0);

    // Push and pop together at occupancy 5 on flow 0
    do_cfg(0, 10);
    for (int j = 0; j < 5; j++) do_wr(0, 8'h10 + j);
    check("pp_head", slice(0), 8'h10);
    rd = 4'b0001;
    do_wr(0, 8'h15);
    check("pp_head_adv", slice(0), 8'h11);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("pp_drain_%0d", j), slice(0), 8'h11 + j);
      check($sformatf("pp_nempty_%0d", j), empty[0], 0);
      tick();
    end
    rd = '0;
    check("pp_empty", empty[0], 1);

    // Drain flow 3, then pop it again while empty
    rd = 4'b1000;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("e3_drain_%0d", j), slice(3), 8'hA0 + j);
      tick();
    end
    check("e3_empty", empty[3], 1);
    tick();
    rd = '0;
    check("e3_empty_rd", empty[3], 1);
    check("e3_dout",     slice(3), 8'h00);
    check("e3_err",      err,      4'b0110);

    // Interleaved flows, round robin, all flows popping continuously
    for (int k = 0; k < FLUX; k++) do_cfg(k, 529);
    check("il_done0", done, 4'h0);
    rd = 4'hF;
    for (int n = 0; n < 529; n++) begin
      for (int k = 0; k < FLUX; k++) begin
        din   = {TAG_W'(k), DATA_W'((k << 6) | (n & 6'h3F))};
        write = 1'b1;
        tick();
        check($sformatf("il_f%0d_w%0d", k, n), slice(k), (k << 6) | (n & 6'h3F));
      end
    end
    write = 1'b0;
    check("il_done", done, 4'hF);
    check("il_err",  err,  4'b0110);
    check("il_full", full, 4'h0);
    tick();
    rd = '0;
    check("il_empty", empty, 4'hF);

    // Reset in the middle of a frame
    do_cfg(0, 256);
    rd = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      din   = {TAG_W'(0), DATA_W'(i)};
      write = 1'b1;
      tick();
    end
    write = 1'b0;
    rd    = '0;
    check("mr_pre_empty", empty[0], 0);
    check("mr_pre_dout",  slice(0), 8'd99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_full",  full,  4'h0);
    check("mr_empty", empty, 4'hF);
    check("mr_done",  done,  4'h0);
    check("mr_err",   err,   4'h0);
    check("mr_dout",  dout,  32'h0);
    do_wr(0, 8'h33);
    check("mr_nocfg_err",   err,   4'b0001);
    check("mr_nocfg_empty", empty, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flow_out_collector.md
# flow_out_collector

Receiving end of the tagged multi-flow write interface driven by `top_ms`. It accepts tagged output pels (`din[TAG_W+DATA_W-1:DATA_W]` = flow id, low bits = data) and demultiplexes them into per-flow show-ahead FIFOs. It applies per-flow back-pressure through `full[FLUX-1:0]` and counts each flow's frame against a configured expected length. It raises a per-flow `done` when the frame completes. It sits between the accelerator output port and the per-flow downstream consumers (DMA or host readers).

## Interface
- `FLUX`, 4: number of flows; `TAG_W = $clog2(FLUX)` (min 1)
- `DEPTH`, 16: per-flow FIFO depth in words (power of 2, ≥2)
- `DATA_W`, 8: pel data width
- `CNT_W`, 13: frame length counter width (covers 64×64 = 4096)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `din` in TAG_W+DATA_W: tagged input word, `{tag, data}`
- `write` in 1: `din` valid this cycle
- `full` out FLUX: per-flow back-pressure; producer must not write flow i while `full[i]`=1
- `cfg_din` in TAG_W+CNT_W: `{tag, expected_count}` frame setup word
- `cfg_write` in 1: `cfg_din` valid this cycle
- `rd` in FLUX: per-flow read strobe
- `dout` out FLUX*DATA_W: per-flow head-of-FIFO data; flow i at `[i*DATA_W +: DATA_W]`
- `empty` out FLUX: per-flow FIFO empty
- `done` out FLUX: per-flow frame complete, level
- `err` out FLUX: per-flow sticky error (overflow or unexpected data)

## Operation
- Per-flow FSM has three states: IDLE, ACTIVE, DONE. Reset puts every flow in IDLE.
- `cfg_write` with tag t loads `exp[t]=expected_count` and clears `rcv[t]` and `done[t]`. Flow t goes to ACTIVE. If `expected_count`=0, flow t goes straight to DONE.
- A config to an ACTIVE or DONE flow restarts it. The FIFO contents are kept.
- On `write` with tag t: if flow t is ACTIVE and `full[t]`=0, the data is pushed into FIFO t and `rcv[t]` increments.
- When `rcv[t]+1 == exp[t]` on an accepted write, flow t goes to DONE.
- `done[t]` is 1 exactly while flow t is in DONE.
- Write to flow t while `full[t]`=1: data dropped, `err[t]` set, `rcv[t]` unchanged.
- Write to flow t in IDLE or DONE: data dropped, `err[t]` set.
- Tag ≥ FLUX (non-power-of-2 FLUX only): data dropped, no state change, no flag.
- `err` bits clear only on `rst`.
- Same-cycle `cfg_write` and `write` to the same flow: the config applies first. The data is judged against the new ACTIVE state, so `rcv` becomes 1 and the word is pushed if not full.
- FIFOs are show-ahead. `dout` slice i shows the head word whenever `empty[i]`=0.
- `rd[i]` pops flow i. `rd[i]` while `empty[i]`=1 is ignored.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH)+1` bits.
- Flows are fully independent. Different-flow write, read and config in the same cycle all take effect.

## Timing
- Reset values, applied at the first rising edge with `rst`=1: `full`=0, `empty`=all 1, `done`=0, `err`=0, `dout`=0, all counters and pointers 0, all flows IDLE.
- `rst` asserted mid-frame discards all FIFO data and counts on that edge.
- Write-to-read latency is 1 cycle: a word accepted at edge N gives `empty[t]`=0 and valid `dout` after edge N.
- `full[i]` is registered, `(occupancy==DEPTH)`, and updates the cycle after the write that fills the FIFO.
- A write arriving while `full[i]`=1 is dropped even if `rd[i]` pops in the same cycle. There is no write-through when full.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves occupancy unchanged. The head advances.
- Pop of the last word: `empty[i]`=1 after that edge, unless a push happened in the same cycle.
- `done[t]` rises after the edge that accepts word `exp[t]`. It is independent of whether the FIFO has drained.
- `err[t]` rises after the edge of the offending write.

## Test plan
- **Single flow:** reset, then cfg `{0,256}`, then 256 writes tag 0 with data i&0xFF while `rd[0]`=1 every cycle.
  - `dout[7:0]` sequence is 0..255.
  - `done[0]`=1 one cycle after write 256; `err`=0.
- **Back-pressure:** cfg `{2,20}`, `rd`=0, 20 back-to-back writes tag 2.
  - `full[2]`=1 after write 16.
  - Writes 17..20 are dropped and `err[2]`=1.
  - Draining 16 reads gives data 0..15; `done[2]`=0 with `rcv`=16.
- **Interleaved flows:** cfg flows 0..3 with 529 each, then round-robin writes tags 0,1,2,3 with the real `top_ms` output order.
  - Each FIFO yields only its own flow's data.
  - All `done` bits set; no cross-flow corruption.
- **Unexpected data:** write tag 1 with no prior cfg → dropped, `err[1]`=1, `empty[1]`=1. Then cfg `{1,0}` → `done[1]`=1 next cycle.
- **Simultaneous events:**
  - cfg `{3,4}` and write tag 3 in the same cycle → `rcv[3]`=1; three more writes give `done[3]`=1.
  - Push+pop at occupancy 5 keeps occupancy at 5.
  - `rd[3]` on empty is ignored.
- **Reset mid-frame:** assert `rst` for one cycle after 100 of 256 writes → all outputs return to reset values. The flow needs a new cfg before accepting data.
